// File: rtl/led_status_ctrl.sv
// Board status LED controller: PLL lock qualification, run/fault FSM,
// heartbeat and fault-code blink on active-low LEDs.
module led_status_ctrl #(
    parameter int TICK_DIV   = 2_700_000,
    parameter int LOCK_TICKS = 5,
    parameter int HB_TICKS   = 5
) (
    input  logic       clk_27m,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       err_valid,
    input  logic [2:0] err_code,
    output logic       err_ready,
    input  logic       err_clear,
    output logic       sys_ok,
    output logic [5:0] led
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int LW = $clog2(LOCK_TICKS + 1);
    localparam int HW = (HB_TICKS > 1) ? $clog2(HB_TICKS) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_TICKS - 1);
    localparam logic [HW-1:0] HB_MAX   = HW'(HB_TICKS - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        RUN       = 2'd1,
        FAULT     = 2'd2
    } state_t;

    state_t        state;
    state_t        state_d;
    logic          lock_m;
    logic          lock_s;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [LW-1:0] lock_cnt;
    logic [2:0]    code;
    logic [4:0]    blink_cnt;
    logic [4:0]    blink_last;
    logic          blink_on;
    logic [HW-1:0] hb_cnt;
    logic          hb;
    logic [5:0]    led_d;

    // Two-flop synchroniser for the asynchronous PLL lock
    always_ff @(posedge clk_27m) begin
        if (!rst_n) {lock_s, lock_m} <= 2'b00;
        else        {lock_s, lock_m} <= {lock_m, pll_lock};
    end

    assign tick = (tick_cnt == TICK_MAX);

    // Free-running status tick divider
    always_ff @(posedge clk_27m) begin
        if (!rst_n || tick) tick_cnt <= '0;
        else                tick_cnt <= tick_cnt + TW'(1);
    end

    // FSM state register
    always_ff @(posedge clk_27m) begin
        if (!rst_n) state <= WAIT_LOCK;
        else        state <= state_d;
    end

    // FSM next-state; lock loss outranks an error report in RUN
    always_comb begin
        state_d = state;
        case (state)
            WAIT_LOCK: if (tick && lock_s && lock_cnt == LOCK_MAX) state_d = RUN;
            RUN:       if (!lock_s || (err_valid && err_ready && err_code != 3'd0))
                           state_d = FAULT;
            FAULT:     if (err_clear) state_d = WAIT_LOCK;
            default:   state_d = WAIT_LOCK;
        endcase
    end

    // FSM outputs: handshake, blink decode and next LED image
    always_comb begin
        err_ready  = (state == RUN) && lock_s;
        blink_last = 5'({code, 1'b0}) + 5'd2;
        blink_on   = (state == FAULT) && !blink_cnt[0]
                  && (blink_cnt < 5'({code, 1'b0}));
        led_d      = {~(state == FAULT), ~(state == WAIT_LOCK), ~blink_on,
                      ~(state == RUN), ~lock_s, ~hb};
    end

    // Consecutive locked ticks, only meaningful while qualifying
    always_ff @(posedge clk_27m) begin
        if (!rst_n || state != WAIT_LOCK || !lock_s) lock_cnt <= '0;
        else if (tick)
            lock_cnt <= (lock_cnt == LOCK_MAX) ? '0 : lock_cnt + LW'(1);
    end

    // Latched fault code; 7 marks lock loss
    always_ff @(posedge clk_27m) begin
        if (!rst_n)
            code <= 3'd0;
        else if (state == RUN && state_d == FAULT)
            code <= lock_s ? err_code : 3'd7;
        else if (state == FAULT && err_clear)
            code <= 3'd0;
    end

    // Blink phase in ticks; last pulse's gap merges into the 4-tick pause
    always_ff @(posedge clk_27m) begin
        if (!rst_n || state != FAULT) blink_cnt <= '0;
        else if (tick)
            blink_cnt <= (blink_cnt >= blink_last) ? '0 : blink_cnt + 5'd1;
    end

    // Heartbeat toggle every HB_TICKS ticks, independent of state
    always_ff @(posedge clk_27m) begin
        if (!rst_n) begin
            hb_cnt <= '0;
            hb     <= 1'b0;
        end else if (tick) begin
            if (hb_cnt == HB_MAX) begin
                hb_cnt <= '0;
                hb     <= ~hb;
            end else begin
                hb_cnt <= hb_cnt + HW'(1);
            end
        end
    end

    // Registered board outputs
    always_ff @(posedge clk_27m) begin
        if (!rst_n) begin
            sys_ok <= 1'b0;
            led    <= 6'b111111;
        end else begin
            sys_ok <= (state == RUN);
            led    <= led_d;
        end
    end

endmodule

// File: tb/tb_led_status_ctrl.sv
// Scoreboard bench for led_status_ctrl with TICK_DIV=4, LOCK_TICKS=3,
// HB_TICKS=2; expectations are keyed by cycle number.
module tb_led_status_ctrl;
    logic       clk_27m = 1'b0;
    logic       rst_n;
    logic       pll_lock;
    logic       err_valid;
    logic [2:0] err_code;
    logic       err_ready;
    logic       err_clear;
    logic       sys_ok;
    logic [5:0] led;

    int cyc     = 0;
    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int         c;
        string      nm;
        logic [7:0] mask;
        logic [7:0] val;
    } exp_t;

    exp_t q[$];

    led_status_ctrl #(
        .TICK_DIV  (4),
        .LOCK_TICKS(3),
        .HB_TICKS  (2)
    ) dut (
        .clk_27m  (clk_27m),
        .rst_n    (rst_n),
        .pll_lock (pll_lock),
        .err_valid(err_valid),
        .err_code (err_code),
        .err_ready(err_ready),
        .err_clear(err_clear),
        .sys_ok   (sys_ok),
        .led      (led)
    );

    always #5 clk_27m = ~clk_27m;

    always @(posedge clk_27m) cyc <= cyc + 1;

    task automatic chk(input int c, input string nm,
                       input logic [7:0] mask, input logic [7:0] val);
        exp_t e;
        int   i;
        e.c    = c;
        e.nm   = nm;
        e.mask = mask;
        e.val  = val;
        i = 0;
        while (i < q.size() && q[i].c <= c) i++;
        q.insert(i, e);
    endtask

    task automatic chk_led(input int c, input string nm, input int b,
                           input logic v);
        logic [7:0] m;
        m = 8'h01 << b;
        chk(c, nm, m, v ? m : 8'h00);
    endtask

    task automatic chk_ok(input int c, input string nm, input logic v);
        chk(c, nm, 8'h40, v ? 8'h40 : 8'h00);
    endtask

    task automatic chk_rdy(input int c, input string nm, input logic v);
        chk(c, nm, 8'h80, v ? 8'h80 : 8'h00);
    endtask

    task automatic go(input int c);
        while (cyc < c) begin
            @(posedge clk_27m);
            #1;
        end
    endtask

    initial begin : monitor
        logic [7:0] obs;
        exp_t       e;
        forever begin
            @(negedge clk_27m);
            obs = {err_ready, sys_ok, led};
            while (q.size() > 0 && q[0].c <= cyc) begin
                e = q.pop_front();
                n_total++;
                if (e.c < cyc)
                    $display("FAIL %s: cycle %0d missed (now %0d)",
                             e.nm, e.c, cyc);
                else if ((obs & e.mask) !== e.val)
                    $display("FAIL %s @cyc %0d: got %b want %b (mask %b)",
                             e.nm, cyc, obs & e.mask, e.val, e.mask);
                else
                    n_pass++;
            end
        end
    end

    initial begin : stim
        int   r;
        exp_t e;
        rst_n     = 1'b0;
        pll_lock  = 1'b1;
        err_valid = 1'b0;
        err_code  = 3'd0;
        err_clear = 1'b0;

        // Power-up qualification with a steady lock
        r = 3;
        chk(r, "rst_state", 8'hFF, 8'b00_111111);
        go(r);
        rst_n = 1'b1;
        chk_led(r + 1, "wait_led4", 4, 1'b0);
        chk_led(r + 1, "led1_unsync", 1, 1'b1);
        chk_led(r + 3, "led1_synced", 1, 1'b0);
        chk_ok(r + 12, "ok_not_yet", 1'b0);
        chk(r + 12, "pre_run_img", 8'hFF, 8'b10_101100);
        chk(r + 13, "run_img", 8'hFF, 8'b11_111000);
        chk_led(r + 16, "hb_on", 0, 1'b0);
        chk_led(r + 17, "hb_off", 0, 1'b1);

        // Reset in RUN
        go(r + 20);
        rst_n = 1'b0;
        chk(r + 21, "rst_in_run", 8'hFF, 8'b00_111111);
        go(r + 23);
        rst_n = 1'b1;
        r = r + 23;

        // One-cycle lock glitch after two qualified ticks
        chk_led(r + 12, "glitch_led1", 1, 1'b1);
        chk_ok(r + 13, "glitch_no_run", 1'b0);
        chk_ok(r + 21, "requal_wait", 1'b0);
        chk_rdy(r + 23, "rdy_wait", 1'b0);
        chk_rdy(r + 24, "rdy_run", 1'b1);
        chk_ok(r + 24, "ok_latency", 1'b0);
        chk_ok(r + 25, "requal_run", 1'b1);
        go(r + 9);
        pll_lock = 1'b0;
        go(r + 10);
        pll_lock = 1'b1;

        // Error code 3 in RUN
        go(r + 30);
        err_valid = 1'b1;
        err_code  = 3'd3;
        chk_rdy(r + 30, "err3_ready", 1'b1);
        chk_ok(r + 31, "err3_ok_lag", 1'b1);
        chk_rdy(r + 31, "fault_no_rdy", 1'b0);
        chk_ok(r + 32, "fault_ok_low", 1'b0);
        chk_led(r + 32, "fault_led5", 5, 1'b0);
        chk_led(r + 32, "b3_p0", 3, 1'b0);
        chk_led(r + 33, "b3_g0", 3, 1'b1);
        chk_led(r + 37, "b3_p1s", 3, 1'b0);
        chk_led(r + 40, "b3_p1e", 3, 1'b0);
        chk_led(r + 41, "b3_g1", 3, 1'b1);
        chk_led(r + 45, "b3_p2s", 3, 1'b0);
        chk_led(r + 48, "b3_p2e", 3, 1'b0);
        chk_led(r + 49, "b3_gap_s", 3, 1'b1);
        chk_led(r + 64, "b3_gap_e", 3, 1'b1);
        chk_led(r + 65, "b3_rep_s", 3, 1'b0);
        chk_led(r + 68, "b3_rep_e", 3, 1'b0);
        chk_led(r + 69, "b3_rep_g", 3, 1'b1);
        chk_led(r + 73, "b3_rep_p", 3, 1'b0);
        go(r + 31);
        err_valid = 1'b0;
        err_code  = 3'd0;

        // Clear with a concurrent error report
        go(r + 75);
        err_clear = 1'b1;
        err_valid = 1'b1;
        err_code  = 3'd2;
        chk_rdy(r + 75, "clr_no_rdy", 1'b0);
        chk_led(r + 77, "clr_led4", 4, 1'b0);
        chk_led(r + 77, "clr_led5", 5, 1'b1);
        chk_led(r + 77, "clr_led3", 3, 1'b1);
        chk_rdy(r + 87, "clr_rdy_wait", 1'b0);
        chk_ok(r + 88, "clr_requal_w", 1'b0);
        chk_rdy(r + 88, "clr_rdy_run", 1'b1);
        chk_ok(r + 89, "clr_requal_r", 1'b1);
        go(r + 76);
        err_clear = 1'b0;
        err_valid = 1'b0;
        err_code  = 3'd0;

        // Code 0 is accepted and dropped
        go(r + 89);
        err_valid = 1'b1;
        err_code  = 3'd0;
        chk_rdy(r + 89, "nop_ready", 1'b1);
        chk_ok(r + 91, "nop_stay_run", 1'b1);
        chk_led(r + 91, "nop_led5", 5, 1'b1);
        go(r + 90);
        err_valid = 1'b0;
        pll_lock  = 1'b0;

        // Lock loss coinciding with an error report
        go(r + 92);
        err_valid = 1'b1;
        err_code  = 3'd5;
        chk_rdy(r + 92, "loss_no_rdy", 1'b0);
        chk_led(r + 93, "loss_led1", 1, 1'b1);
        chk_ok(r + 93, "loss_ok_lag", 1'b1);
        chk_ok(r + 94, "loss_ok_low", 1'b0);
        chk_led(r + 94, "loss_led5", 5, 1'b0);
        chk_led(r + 94, "b7_p0", 3, 1'b0);
        chk_led(r + 97, "b7_g0", 3, 1'b1);
        chk_led(r + 101, "b7_p1", 3, 1'b0);
        chk_led(r + 120, "relock_ign", 5, 1'b0);
        chk_led(r + 141, "b7_p7", 3, 1'b0);
        chk_led(r + 145, "b7_gap_s", 3, 1'b1);
        chk_led(r + 160, "b7_gap_e", 3, 1'b1);
        chk_led(r + 161, "b7_rep", 3, 1'b0);
        go(r + 93);
        err_valid = 1'b0;
        err_code  = 3'd0;
        pll_lock  = 1'b1;

        // Reset in FAULT
        go(r + 165);
        rst_n = 1'b0;
        chk(r + 166, "rst_in_fault", 8'hFF, 8'b00_111111);
        go(r + 168);
        rst_n = 1'b1;
        r = r + 168;
        chk_led(r + 1, "post_led4", 4, 1'b0);
        chk_led(r + 1, "post_led5", 5, 1'b1);
        chk_led(r + 5, "post_led3", 3, 1'b1);
        chk_ok(r + 12, "post_wait", 1'b0);
        chk_ok(r + 13, "post_run", 1'b1);
        go(r + 20);

        for (int k = 0; k < 50 && q.size() > 0; k++) @(posedge clk_27m);
        while (q.size() > 0) begin
            e = q.pop_front();
            n_total++;
            $display("FAIL %s: never sampled (cycle %0d)", e.nm, e.c);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/led_status_ctrl.md
LED_STATUS_CTRL -- requirements
Module: led_status_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 2_700_000, meaning clk_27m cycles per status tick (10 Hz at 27 MHz).
REQ-002 SHALL have parameter LOCK_TICKS, default 5, meaning consecutive locked ticks required to qualify PLL lock.
REQ-003 SHALL have parameter HB_TICKS, default 5, meaning ticks per heartbeat LED toggle.
REQ-004 SHALL have port clk_27m  input  1  sole clock.
REQ-005 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port pll_lock  input  1  raw PLL lock, asynchronous to clk_27m.
REQ-007 SHALL have port err_valid  input  1  error report request.
REQ-008 SHALL have port err_code  input  3  error code, 1..7; 0 = no-op.
REQ-009 SHALL have port err_ready  output  1  error report accepted when high with err_valid.
REQ-010 SHALL have port err_clear  input  1  single-cycle fault acknowledge.
REQ-011 SHALL have port sys_ok  output  1  high only in RUN.
REQ-012 SHALL have port led  output  6  board LEDs, active-low (0 = lit).

Function
REQ-013 SHALL synchronise pll_lock through two flops to lock_s; all logic uses lock_s only.
REQ-014 SHALL generate tick: counter 0..TICK_DIV-1, tick high exactly one cycle when counter = TICK_DIV-1, then wrap to 0.
REQ-015 SHALL implement states WAIT_LOCK, RUN, FAULT.
REQ-016 WAIT_LOCK: lock_cnt increments on tick while lock_s=1; clears on any cycle lock_s=0; on tick where lock_cnt reaches LOCK_TICKS -> RUN, lock_cnt cleared.
REQ-017 RUN: lock_s=0 -> FAULT with latched code 7 (lock loss); else err_valid & err_ready & err_code!=0 -> FAULT with latched err_code.
REQ-018 err_ready SHALL be high only in RUN with lock_s=1; lock loss takes priority over a simultaneous error report.
REQ-019 err_valid with err_code=0 in RUN SHALL be accepted (err_ready high) and discarded, state unchanged.
REQ-020 FAULT: blink sequence restarted on entry; per cycle N pulses of 1 tick lit, 1 tick dark (N = latched code), then 4 dark ticks, repeat.
REQ-021 FAULT: err_clear -> WAIT_LOCK, latched code cleared to 0, lock_cnt cleared; err_clear ignored in other states.
REQ-022 FAULT SHALL not accept new errors (err_ready=0); further lock changes ignored until cleared.
REQ-023 sys_ok SHALL be registered, equal to (state == RUN), one cycle after state update.
REQ-024 led SHALL be registered, one cycle latency from internal state: led[0] heartbeat toggling every HB_TICKS ticks in all states; led[1] = ~lock_s; led[2] = ~sys_ok; led[3] lit during blink pulses in FAULT, dark otherwise; led[4] lit in WAIT_LOCK; led[5] lit steady in FAULT.
REQ-025 Heartbeat and tick counters SHALL run continuously, unaffected by state transitions.

Reset
REQ-026 rst_n=0 sampled on clk_27m edge SHALL set: state WAIT_LOCK, tick/lock/heartbeat/blink counters 0, latched code 0, sync flops 0, led = 6'b111111, sys_ok=0, err_ready=0.
REQ-027 Reset asserted mid-FAULT or mid-RUN SHALL abort immediately; no error code survives reset.
REQ-028 After rst_n release, first tick SHALL occur TICK_DIV cycles later.

Verification (TICK_DIV=4, LOCK_TICKS=3, HB_TICKS=2)
REQ-029 Reset, pll_lock=1 constant -> sys_ok rises after 3 ticks plus sync/register latency (~15 cycles); led[4] 0->1, led[2] 1->0.
REQ-030 pll_lock drops 1 cycle during qualification (after 2 ticks) -> lock_cnt clears; RUN reached only after 3 further consecutive ticks.
REQ-031 RUN, err_valid=1, err_code=3 -> err_ready=1 same cycle; FAULT; led[3] shows 3 lit pulses of 4 cycles, gaps 4 cycles, then 16-cycle dark gap, repeating; sys_ok=0.
REQ-032 RUN, pll_lock=0 same cycle as err_valid=1, err_code=5 -> err_ready=0, latched code 7 (7 pulses).
REQ-033 FAULT, err_clear=1 with err_valid=1 -> WAIT_LOCK, err not accepted; re-qualification required before sys_ok.
REQ-034 rst_n=0 mid-FAULT -> next cycle led=6'b111111, sys_ok=0; after release, WAIT_LOCK with code 0.
